// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V funct3 size/sign codes for loads and stores
//   - FSM state encoding
//   - byte-lane widths and a funct3 legality helper
package lsu_pkg;

    // funct3 codes (bit 2 set = zero-extending load)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane helpers: 4 lanes of 8 bits in a 32-bit word
    localparam int unsigned ByteW = 8;
    localparam int unsigned HalfW = 16;
    localparam int unsigned LaneW = 2;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRead   = 3'd1,
        StMerge  = 3'd2,
        StWrite  = 3'd3,
        StLoadWb = 3'd4,
        StDone   = 3'd5
    } lsu_state_e;

    // Stores only know B/H/W; loads additionally have the unsigned variants
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   we_i          1 = store, 0 = load
//   funct3_i      RISC-V size/sign code
//   offset_i      byte offset within the word (addr[1:0])
//   rdata_i       word read from RAM
//   wdata_i       store data (low bytes used for SB/SH)
//   load_data_o   extracted, sign/zero-extended load result
//   merge_data_o  RAM word with the store lane(s) replaced
//   err_o         illegal funct3 or misaligned access
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic             we_i,
    input  logic [2:0]       funct3_i,
    input  logic [LaneW-1:0] offset_i,
    input  logic [N-1:0]     rdata_i,
    input  logic [N-1:0]     wdata_i,
    output logic [N-1:0]     load_data_o,
    output logic [N-1:0]     merge_data_o,
    output logic             err_o
);

    logic [N-1:0] shifted;
    logic         misaligned;

    // Alignment depends only on the size bits; illegal codes are caught by f3_legal
    always_comb begin
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b01:   misaligned = offset_i[0];
            2'b10:   misaligned = (offset_i != 2'b00);
            default: misaligned = 1'b0;
        endcase
        err_o = ~f3_legal(we_i, funct3_i) | misaligned;
    end

    // Load path: bring the addressed lane down to bit 0, then extend
    always_comb begin
        shifted     = rdata_i >> {offset_i, 3'b000};
        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{(N - ByteW){shifted[ByteW-1]}}, shifted[ByteW-1:0]};
            F3_BU:   load_data_o = {{(N - ByteW){1'b0}}, shifted[ByteW-1:0]};
            F3_H:    load_data_o = {{(N - HalfW){shifted[HalfW-1]}}, shifted[HalfW-1:0]};
            F3_HU:   load_data_o = {{(N - HalfW){1'b0}}, shifted[HalfW-1:0]};
            default: load_data_o = rdata_i;
        endcase
    end

    // Store path: overwrite only the target lane(s) of the word just read
    always_comb begin
        merge_data_o = rdata_i;
        case (funct3_i)
            F3_B:    merge_data_o[{offset_i, 3'b000} +: ByteW] = wdata_i[ByteW-1:0];
            F3_H:    merge_data_o[{offset_i[1], 4'b0000} +: HalfW] = wdata_i[HalfW-1:0];
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RISC-V loads/stores into word accesses
// on a RAM with one-cycle registered read.
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only when idle)
//   req_we            1 = store, 0 = load
//   req_funct3        size/sign code
//   req_addr          byte address (bits above ADDR_W+1 ignored)
//   req_wdata         store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result, 0 for stores/errors, held until next completion
//   resp_err          misaligned or illegal funct3, held until next completion
//   mem_we/addr/wdata RAM write enable, word address, write data
//   mem_rdata         RAM read data, valid the cycle after mem_addr
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [N-1:0]      req_wdata,
    output logic              resp_valid,
    output logic [N-1:0]      resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    input  logic [N-1:0]      mem_rdata
);

    localparam int unsigned AW = ADDR_W + 2;

    lsu_state_e state_q, state_d;

    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [N-1:0]  rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          idle;
    logic          accept;
    logic          cur_we;
    logic [2:0]    cur_funct3;
    logic [AW-1:0] cur_addr;
    logic [N-1:0]  load_data;
    logic [N-1:0]  merge_data;
    logic          align_err;

    // Upper address bits are ignored so word addresses wrap
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];

    assign idle   = (state_q == StIdle);
    assign accept = req_valid & req_ready;

    // The error check must see the live request in IDLE; later the latched copy
    assign cur_we     = idle ? req_we     : we_q;
    assign cur_funct3 = idle ? req_funct3 : funct3_q;
    assign cur_addr   = idle ? req_addr[AW-1:0] : addr_q;

    lsu_align #(
        .N (N)
    ) u_align (
        .we_i         (cur_we),
        .funct3_i     (cur_funct3),
        .offset_i     (cur_addr[LaneW-1:0]),
        .rdata_i      (mem_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data),
        .err_o        (align_err)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[AW-1:0];
                    wdata_d  = req_wdata;
                    if (align_err) begin
                        state_d = StDone;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                state_d = we_q ? StMerge : StLoadWb;
            end
            StMerge, StWrite: begin
                state_d = StDone;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            StLoadWb: begin
                state_d = StDone;
                rdata_d = load_data;
                err_d   = 1'b0;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Gating with rst keeps a reset that lands mid-store from reaching the RAM
    assign req_ready  = idle & ~rst;
    assign resp_valid = (state_q == StDone) & ~rst;
    assign mem_we     = ((state_q == StWrite) | (state_q == StMerge)) & ~rst;
    assign mem_addr   = addr_q[AW-1:2];
    assign mem_wdata  = (state_q == StMerge) ? merge_data : wdata_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned N      = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned SIZE   = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [N-1:0]      req_wdata;
    logic              resp_valid;
    logic [N-1:0]      resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_wdata;
    logic [N-1:0]      mem_rdata;

    load_store_unit #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data RAM: registered read, write-first on the same address
    logic [31:0] ram [0:SIZE-1];
    logic [31:0] ram_rdata;
    initial begin
        for (int i = 0; i < int'(SIZE); i++) ram[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end
    assign mem_rdata = ram_rdata;

    // Reference model state
    logic [31:0] ref_mem [0:SIZE-1];
    initial for (int i = 0; i < int'(SIZE); i++) ref_mem[i] = '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_en = 0;
    int          acc_cyc  = -10;
    int          end_cyc  = -10;
    int          we_cyc   = -10;
    int          done_cyc = -10;
    logic [31:0] exp_rd_new = '0, exp_rd_old = '0;
    logic        exp_err_new = 1'b0, exp_err_old = 1'b0;
    logic [9:0]  exp_maddr = '0;
    logic [31:0] exp_wword = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int f3_size(input logic [2:0] f3);
        return 1 << int'(f3[1:0]);
    endfunction

    function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                        (f3 == 3'd4) || (f3 == 3'd5);
        return !legal || ((int'(a[1:0]) % f3_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int          sz;
        sz = f3_size(f3);
        v  = ref_mem[int'(a[11:2])] >> (8 * int'(a[1:0]));
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] wd);
        logic [31:0] w;
        int          off;
        w   = ref_mem[int'(a[11:2])];
        off = int'(a[1:0]);
        for (int i = 0; i < f3_size(f3); i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    // Per-cycle comparison against the model's schedule
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready),
                32'(!rst && !(cyc >= acc_cyc && cyc <= end_cyc)));
            chk("mem_we", 32'(mem_we), 32'(cyc == we_cyc));
            chk("resp_valid", 32'(resp_valid), 32'(cyc == done_cyc && !rst));
            if (cyc >= done_cyc) begin
                chk("resp_rdata", resp_rdata, exp_rd_new);
                chk("resp_err", 32'(resp_err), 32'(exp_err_new));
            end else begin
                chk("resp_rdata_hold", resp_rdata, exp_rd_old);
                chk("resp_err_hold", 32'(resp_err), 32'(exp_err_old));
            end
            if (cyc == we_cyc) chk("mem_wdata", mem_wdata, exp_wword);
            if (cyc >= acc_cyc && cyc <= end_cyc) chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
        end
    end

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, input bit lit_en,
                         input logic [31:0] lit);
        bit err;
        int c0;
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        c0          = cyc;
        err         = model_err(we, f3, a);
        exp_rd_old  = exp_rd_new;
        exp_err_old = exp_err_new;
        exp_maddr   = a[11:2];
        acc_cyc     = c0;
        we_cyc      = -10;
        if (err) begin
            done_cyc    = c0;
            exp_rd_new  = '0;
            exp_err_new = 1'b1;
        end else if (!we) begin
            done_cyc    = c0 + 2;
            exp_rd_new  = model_load(f3, a);
            exp_err_new = 1'b0;
        end else begin
            done_cyc    = (f3 == 3'd2) ? c0 + 1 : c0 + 2;
            we_cyc      = done_cyc - 1;
            exp_wword   = model_store(f3, a, wd);
            ref_mem[int'(a[11:2])] = exp_wword;
            exp_rd_new  = '0;
            exp_err_new = 1'b0;
        end
        end_cyc = done_cyc;
        if (!hold) req_valid = 1'b0;
        while (cyc < done_cyc) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        if (lit_en) chk("literal", resp_rdata, lit);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        @(posedge clk);
        #1;
        chk_en = 1;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SW then LW
        issue(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        issue(0, 3'd2, 32'h10, 0, 0, 1, 32'hDEADBEEF);
        // Sub-word loads
        issue(0, 3'd0, 32'h13, 0, 0, 1, 32'hFFFFFFDE);
        issue(0, 3'd4, 32'h13, 0, 0, 1, 32'h000000DE);
        issue(0, 3'd1, 32'h12, 0, 0, 1, 32'hFFFFDEAD);
        issue(0, 3'd5, 32'h10, 0, 0, 1, 32'h0000BEEF);
        issue(0, 3'd0, 32'h10, 0, 1, 1, 32'hFFFFFFEF);
        // Sub-word stores
        issue(1, 3'd0, 32'h11, 32'h12345677, 0, 0, 0);
        issue(0, 3'd2, 32'h10, 0, 0, 1, 32'hDEAD77EF);
        issue(1, 3'd1, 32'h12, 32'h0000CAFE, 1, 0, 0);
        issue(0, 3'd2, 32'h10, 0, 0, 1, 32'hCAFE77EF);
        // Errors
        issue(0, 3'd2, 32'h12, 0, 0, 1, 32'h0);
        issue(1, 3'd1, 32'h13, 32'hFFFFFFFF, 0, 1, 32'h0);
        issue(0, 3'd3, 32'h10, 0, 0, 1, 32'h0);
        issue(1, 3'd4, 32'h10, 32'hFFFFFFFF, 0, 1, 32'h0);
        issue(0, 3'd2, 32'h10, 0, 0, 1, 32'hCAFE77EF);
        // Wrap
        issue(1, 3'd2, 32'h1010, 32'h0BADF00D, 0, 0, 0);
        issue(0, 3'd2, 32'h10, 0, 0, 1, 32'h0BADF00D);

        // Reset while the SB sits in MERGE
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h10;
        req_wdata  = 32'h000000AA;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        exp_maddr = 10'd4;
        acc_cyc   = cyc;
        end_cyc   = cyc + 1;
        we_cyc    = -10;
        done_cyc  = -10;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        exp_rd_new  = '0;
        exp_err_new = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        issue(0, 3'd2, 32'h10, 0, 0, 1, 32'h0BADF00D);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
